// File: rtl/memory_pkg.sv
// ---------------------------------------------------------------------------
// memory_pkg
// Shared definitions for the byte-lane memory block.
//   state_t  : clear-sequencer states (ST_IDLE, ST_CLEAR)
//   RDW_OLD  : a read that collides with a write returns the pre-write word
//   RDW_NEW  : a read that collides with a write returns the merged word
// ---------------------------------------------------------------------------
package memory_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

endpackage : memory_pkg

// File: rtl/bytelane_ram.sv
// ---------------------------------------------------------------------------
// bytelane_ram
// Single-port RAM built from W independent byte lanes, with a synchronous
// read-first output register. The array has no reset; it is zeroed by the
// clear sequencer in memory_bytelane.
// Ports:
//   clk       : rising-edge clock
//   i_addr    : word address shared by read and write
//   i_wdata   : write data, lane i is bits [8i+7:8i]
//   i_lane_we : per-lane write enable
//   i_re      : read enable; loads o_rdata with the pre-write word
//   o_rdata   : registered read word, holds when i_re is low
// ---------------------------------------------------------------------------
module bytelane_ram #(
    parameter int W      = 1,
    parameter int Addr_W = 8
) (
    input  logic                clk,
    input  logic [Addr_W-1:0]   i_addr,
    input  logic [8*W-1:0]      i_wdata,
    input  logic [W-1:0]        i_lane_we,
    input  logic                i_re,
    output logic [8*W-1:0]      o_rdata
);

    localparam int Depth = 2 ** Addr_W;

    logic [8*W-1:0] r_mem [0:Depth-1];
    logic [8*W-1:0] r_rdata;

    // Read-first port: the output register samples the array before this
    // edge's lane writes land, so a colliding read sees the old word.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
        for (int i = 0; i < W; i++) begin
            if (i_lane_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule : bytelane_ram

// File: rtl/memory_bytelane.sv
// ---------------------------------------------------------------------------
// memory_bytelane
// Byte-enabled single-port memory with a clear sequencer that zeroes the
// whole array one word per cycle (automatically after reset, or on request).
// Ports:
//   clk, reset       : clock and asynchronous active-high reset
//   inp_address      : word address for read and write
//   inp_data         : write data (byte i = bits [8i+7:8i])
//   inp_byte_enable  : per-byte write strobe
//   write_enable     : write request
//   read_enable      : read request
//   inp_clear        : request to zero the array (wins over read/write)
//   out_read_data    : read word, valid one cycle after an accepted read
//   out_read_valid   : one-cycle qualifier for out_read_data
//   out_busy         : high while the clear sequence runs
// ---------------------------------------------------------------------------
module memory_bytelane
    import memory_pkg::*;
#(
    parameter int W        = 1,
    parameter int Addr_W   = 8,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [Addr_W-1:0]   inp_address,
    input  logic [8*W-1:0]      inp_data,
    input  logic [W-1:0]        inp_byte_enable,
    input  logic                write_enable,
    input  logic                read_enable,
    input  logic                inp_clear,
    output logic [8*W-1:0]      out_read_data,
    output logic                out_read_valid,
    output logic                out_busy
);

    state_t              r_state;
    logic [Addr_W-1:0]   r_clearCount;
    logic                r_busy;
    logic                r_readValid;
    logic [8*W-1:0]      r_bypassData;
    logic [W-1:0]        r_bypassMask;

    logic                w_accessOk;
    logic                w_wrAccept;
    logic                w_rdAccept;
    logic [Addr_W-1:0]   w_ramAddr;
    logic [8*W-1:0]      w_ramWdata;
    logic [W-1:0]        w_ramLaneWe;
    logic [8*W-1:0]      w_ramRdata;

    // Requests are only honoured in IDLE, and a clear request in the same
    // cycle drops them.
    assign w_accessOk = (r_state == ST_IDLE) && !inp_clear;
    assign w_wrAccept = w_accessOk && write_enable;
    assign w_rdAccept = w_accessOk && read_enable;

    // While clearing, the sequencer owns the RAM port and writes zero words.
    always_comb begin
        w_ramAddr   = inp_address;
        w_ramWdata  = inp_data;
        w_ramLaneWe = '0;
        if (r_state == ST_CLEAR) begin
            w_ramAddr   = r_clearCount;
            w_ramWdata  = '0;
            w_ramLaneWe = '1;
        end else if (w_wrAccept) begin
            w_ramLaneWe = inp_byte_enable;
        end
    end

    bytelane_ram #(
        .W      (W),
        .Addr_W (Addr_W)
    ) u_ram (
        .clk       (clk),
        .i_addr    (w_ramAddr),
        .i_wdata   (w_ramWdata),
        .i_lane_we (w_ramLaneWe),
        .i_re      (w_rdAccept),
        .o_rdata   (w_ramRdata)
    );

    // Clear sequencer. Reset lands in CLEAR at address 0 so the array is
    // always zeroed before first use; completion is the all-ones count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_CLEAR;
            r_clearCount <= '0;
            r_busy       <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (inp_clear) begin
                        r_state      <= ST_CLEAR;
                        r_clearCount <= '0;
                        r_busy       <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (r_clearCount == '1) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clearCount <= r_clearCount + Addr_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_clearCount <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // Read-side bookkeeping. The RAM always returns the pre-write word; for
    // the new-data collision mode the written bytes are captured here and
    // overlaid on the RAM output. Reset selects an all-zero overlay so the
    // read data reads as zero without resetting the RAM's output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readValid  <= 1'b0;
            r_bypassData <= '0;
            r_bypassMask <= '1;
        end else begin
            r_readValid <= w_rdAccept;
            if (w_rdAccept) begin
                r_bypassData <= inp_data;
                if ((RDW_MODE == RDW_NEW) && w_wrAccept) begin
                    r_bypassMask <= inp_byte_enable;
                end else begin
                    r_bypassMask <= '0;
                end
            end
        end
    end

    // Per-byte overlay of captured write bytes onto the RAM read word.
    always_comb begin
        out_read_data = w_ramRdata;
        for (int i = 0; i < W; i++) begin
            if (r_bypassMask[i]) begin
                out_read_data[8*i +: 8] = r_bypassData[8*i +: 8];
            end
        end
    end

    assign out_read_valid = r_readValid;
    assign out_busy       = r_busy;

endmodule : memory_bytelane

// File: tb/tb_memory_bytelane.sv
// ---------------------------------------------------------------------------
// tb_memory_bytelane
// Drives two copies of memory_bytelane (old-data and new-data collision
// modes) with the same stimulus and compares both against a word-array
// reference model held in the bench.
// ---------------------------------------------------------------------------
module tb_memory_bytelane;

    localparam int W      = 4;
    localparam int Addr_W = 4;
    localparam int Depth  = 16;

    logic              clk;
    logic              reset;
    logic [Addr_W-1:0] inp_address;
    logic [8*W-1:0]    inp_data;
    logic [W-1:0]      inp_byte_enable;
    logic              write_enable;
    logic              read_enable;
    logic              inp_clear;

    logic [8*W-1:0]    rdData0, rdData1;
    logic              rdValid0, rdValid1;
    logic              busy0, busy1;

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    logic [31:0] memModel [0:Depth-1];
    int          busyLeft;
    logic [31:0] expData0;
    logic [31:0] expData1;
    logic        expValid;
    string       stepTag;

    memory_bytelane #(.W(W), .Addr_W(Addr_W), .RDW_MODE(0)) dutOld (
        .clk             (clk),
        .reset           (reset),
        .inp_address     (inp_address),
        .inp_data        (inp_data),
        .inp_byte_enable (inp_byte_enable),
        .write_enable    (write_enable),
        .read_enable     (read_enable),
        .inp_clear       (inp_clear),
        .out_read_data   (rdData0),
        .out_read_valid  (rdValid0),
        .out_busy        (busy0)
    );

    memory_bytelane #(.W(W), .Addr_W(Addr_W), .RDW_MODE(1)) dutNew (
        .clk             (clk),
        .reset           (reset),
        .inp_address     (inp_address),
        .inp_data        (inp_data),
        .inp_byte_enable (inp_byte_enable),
        .write_enable    (write_enable),
        .read_enable     (read_enable),
        .inp_clear       (inp_clear),
        .out_read_data   (rdData1),
        .out_read_valid  (rdValid1),
        .out_busy        (busy1)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expand a byte-enable nibble into a 32-bit bit mask.
    function automatic logic [31:0] byteMask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m[8*i +: 8] = 8'hFF;
        end
        return m;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s %s: observed %h expected %h", stepTag, tag, obs, exp);
        end
    endtask

    // Compare every observable output of both instances with the model.
    task automatic checkOutput();
        checkValue("busyOld",  {31'd0, busy0},    {31'd0, busyLeft > 0});
        checkValue("busyNew",  {31'd0, busy1},    {31'd0, busyLeft > 0});
        checkValue("validOld", {31'd0, rdValid0}, {31'd0, expValid});
        checkValue("validNew", {31'd0, rdValid1}, {31'd0, expValid});
        checkValue("dataOld",  rdData0, expData0);
        checkValue("dataNew",  rdData1, expData1);
    endtask

    // One clock of stimulus, then advance the model and check.
    task automatic applyStimulus(input logic [3:0] addr, input logic [31:0] data,
                                 input logic [3:0] be, input logic we,
                                 input logic re, input logic clr);
        logic [31:0] oldWord;
        inp_address     = addr;
        inp_data        = data;
        inp_byte_enable = be;
        write_enable    = we;
        read_enable     = re;
        inp_clear       = clr;
        @(posedge clk);
        #1;
        expValid = 1'b0;
        if (busyLeft > 0) begin
            busyLeft--;
        end else if (clr) begin
            busyLeft = Depth;
            for (int i = 0; i < Depth; i++) memModel[i] = '0;
        end else begin
            oldWord = memModel[addr];
            if (we) memModel[addr] = (oldWord & ~byteMask(be)) | (data & byteMask(be));
            if (re) begin
                expData0 = oldWord;
                expData1 = memModel[addr];
                expValid = 1'b1;
            end
        end
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset away from the clock edge, hold it across one edge, release.
    task automatic doReset();
        reset = 1'b1;
        #2;
        busyLeft = Depth;
        expValid = 1'b0;
        expData0 = '0;
        expData1 = '0;
        for (int i = 0; i < Depth; i++) memModel[i] = '0;
        checkOutput();
        @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;
    endtask

    // Directed scenarios first, then a randomized soak against the model.
    initial begin
        reset           = 1'b1;
        inp_address     = '0;
        inp_data        = '0;
        inp_byte_enable = '0;
        write_enable    = 1'b0;
        read_enable     = 1'b0;
        inp_clear       = 1'b0;
        busyLeft        = 0;
        expValid        = 1'b0;
        expData0        = '0;
        expData1        = '0;
        #3;

        stepTag = "reset";
        doReset();
        stepTag = "initClear";
        idleCycles(Depth);
        checkValue("busyDone", {31'd0, busy0}, 32'd0);

        stepTag = "readAfterClear";
        applyStimulus(4'h5, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkValue("read5", rdData0, 32'h0000_0000);

        stepTag = "byteMerge";
        applyStimulus(4'h3, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h3, 32'h1122_3344, 4'b0101, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h3, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h3, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkValue("read3", rdData0, 32'hDE22_BE44);
        idleCycles(2);

        stepTag = "readDuringWrite";
        applyStimulus(4'h7, 32'hAAAA_AAAA, 4'b1111, 1'b1, 1'b0, 1'b0);
        applyStimulus(4'h7, 32'h5555_5555, 4'b1111, 1'b1, 1'b1, 1'b0);
        checkValue("rdwOld", rdData0, 32'hAAAA_AAAA);
        checkValue("rdwNew", rdData1, 32'h5555_5555);
        applyStimulus(4'h7, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkValue("laterOld", rdData0, 32'h5555_5555);
        checkValue("laterNew", rdData1, 32'h5555_5555);
        applyStimulus(4'h7, 32'h1234_ABCD, 4'b0110, 1'b1, 1'b1, 1'b0);

        stepTag = "clearWins";
        applyStimulus(4'h2, 32'h1234_5678, 4'b1111, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < Depth; i++) applyStimulus(4'(i), 32'hCAFE_0000, 4'hF, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'h2, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        checkValue("read2", rdData0, 32'h0);

        stepTag = "resetMidClear";
        applyStimulus(4'h9, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) applyStimulus(4'h9, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 1'b0);
        doReset();
        for (int i = 0; i < Depth; i++) applyStimulus(4'h1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(4'h1, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0);

        stepTag = "random";
        for (int n = 0; n < 400; n++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 59) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule : tb_memory_bytelane
